// File: rtl/lfsr_sync_checker.sv
// Receive-side checker for the 8-bit LFSR stream: self-syncs from the data, then flags and counts mismatches.
// Latency: locked, err_pulse and err_cnt update on the edge that samples the word (visible 1 clock later).
// Backpressure: none; words are consumed on every cycle that data_valid is high.
module lfsr_sync_checker #(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       expected
);

    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    // Bit-exact copy of the generator step; s[6] falls off the end.
    function automatic logic [7:0] lfsr_nxt(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {fb, s[5:0], fb};
    endfunction

    state_t     state, state_nxt;
    logic [3:0] match_cnt, match_nxt, match_inc;
    logic [3:0] miss_cnt, miss_nxt, miss_inc;
    logic [7:0] exp_nxt;
    logic       is_match, is_zero, err_hit;

    assign is_match  = (data_in == expected);
    assign is_zero   = (data_in == 8'h00);
    assign match_inc = match_cnt + 4'd1;
    assign miss_inc  = miss_cnt + 4'd1;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= SEARCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (data_valid) begin
            case (state)
                SEARCH: if (!is_zero) state_nxt = VERIFY;
                VERIFY: begin
                    if (is_zero)                              state_nxt = SEARCH;
                    else if (is_match && match_inc == LOCK_C) state_nxt = LOCKED;
                end
                LOCKED: if (!is_match && miss_inc == LOSS_C) state_nxt = VERIFY;
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_comb begin
        exp_nxt   = expected;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        err_hit   = 1'b0;
        if (data_valid) begin
            case (state)
                SEARCH: begin
                    if (!is_zero) begin
                        exp_nxt   = lfsr_nxt(data_in);
                        match_nxt = 4'd0;
                    end
                end
                VERIFY: begin
                    if (is_zero) begin
                        match_nxt = 4'd0;
                    end else if (is_match) begin
                        match_nxt = match_inc;
                        exp_nxt   = lfsr_nxt(data_in);
                        if (match_inc == LOCK_C) miss_nxt = 4'd0;
                    end else begin
                        // Reseed from the new word; misses before lock are not errors.
                        exp_nxt   = lfsr_nxt(data_in);
                        match_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    exp_nxt = lfsr_nxt(expected);
                    if (is_match) begin
                        miss_nxt = 4'd0;
                    end else begin
                        err_hit  = 1'b1;
                        miss_nxt = miss_inc;
                        if (miss_inc == LOSS_C) begin
                            exp_nxt   = lfsr_nxt(data_in);
                            match_nxt = 4'd0;
                        end
                    end
                end
                default: begin
                    exp_nxt   = 8'h00;
                    match_nxt = 4'd0;
                    miss_nxt  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            expected  <= 8'h00;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
            err_cnt   <= '0;
            err_pulse <= 1'b0;
            locked    <= 1'b0;
        end else begin
            expected  <= exp_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            err_pulse <= err_hit;
            locked    <= (state_nxt == LOCKED);
            if (err_clr)
                err_cnt <= '0;
            else if (err_hit && err_cnt != {ERR_W{1'b1}})
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: doc/lfsr_sync_checker.md
Name: lfsr_sync_checker

Overview:
- Receive-side companion to the 8-bit LFSR generator; consumes the generator's 8-bit output words as a stream.
- Self-synchronises by seeding its own copy of the LFSR from the stream and confirming consecutive predictions.
- Once locked, compares every received word against its free-running prediction, flags mismatches and counts them.
- Used to validate the random stream that drives spawn logic, and to detect generator reseeds or corruption.

Parameters:
- LOCK_CNT, 3: consecutive correct predictions required in VERIFY before asserting lock (1..15).
- LOSS_CNT, 2: consecutive mismatches in LOCKED before dropping lock (1..15).
- ERR_W, 16: width of the saturating mismatch counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr_n  in  1  asynchronous active-low reset.
- data_in  in  8  received LFSR word.
- data_valid  in  1  data_in is sampled on rising clk when high; ignored otherwise.
- err_clr  in  1  synchronous clear of err_cnt; takes priority over an increment in the same cycle.
- locked  out  1  high while the FSM is in LOCKED.
- err_pulse  out  1  one-cycle registered pulse per mismatch detected in LOCKED.
- err_cnt  out  ERR_W  saturating count of LOCKED mismatches.
- expected  out  8  current prediction register (next word expected).

Behaviour:
- Step function nxt(s):
  - fb = s[7]^s[5]^s[4]^s[3].
  - nxt[0] = fb; nxt[i] = s[i-1] for i = 1..6; nxt[7] = fb; s[6] is discarded.
  - This is bit-exact with the generator.
- Reset (clr_n low, asynchronous): state=SEARCH, expected=0, match_cnt=0, miss_cnt=0, err_cnt=0, locked=0, err_pulse=0.
- Cycles with data_valid low:
  - No state, prediction or counter change.
  - err_pulse=0.
  - err_clr still acts.
- SEARCH, on valid:
  - data_in == 0x00 (generator lock-up value): stay in SEARCH.
  - Otherwise: expected <= nxt(data_in), match_cnt <= 0, go to VERIFY.
- VERIFY, on valid:
  - data_in == 0x00: go to SEARCH, match_cnt <= 0.
  - data_in == expected:
    - match_cnt++ and expected <= nxt(data_in).
    - If the incremented match_cnt == LOCK_CNT: go to LOCKED, miss_cnt <= 0.
  - Mismatch (non-zero): expected <= nxt(data_in), match_cnt <= 0, stay in VERIFY. The block reseeds from the new word; no error is counted.
- LOCKED, on valid:
  - expected <= nxt(expected) always. The prediction free-runs and is never reseeded from data while locked.
  - Match: miss_cnt <= 0.
  - Mismatch:
    - err_pulse <= 1 on the next cycle.
    - err_cnt increments, saturating at all-ones.
    - miss_cnt++.
    - If the incremented miss_cnt == LOSS_CNT: go to VERIFY, expected <= nxt(data_in), match_cnt <= 0. Lock is dropped; the pulse and count for this word still occur.
- Timing:
  - locked is a registered decode of the state. It rises on the clock edge that samples the LOCK_CNT-th consecutive match and falls on the edge that samples the LOSS_CNT-th consecutive miss.
  - Latency from the sampled word to err_pulse/err_cnt update is 1 clock.
- Prediction collapse: if expected becomes 0x00 while in LOCKED (e.g. after 0x40), it keeps stepping (0x00 -> 0x00). A non-zero stream then produces misses, and the lock drops after LOSS_CNT of them.
- Simultaneous err_clr and mismatch: err_cnt <= 0. err_pulse still asserts.
- Reset asserted mid-stream: everything returns to reset values immediately. After release the block starts in SEARCH, and the first valid non-zero word reseeds it.

Test Plan:
- Lock-on: reset, stream 0x01,0x02,0x04,0x08,0x91,0x22 on consecutive valid cycles.
  - locked rises after 0x08 is sampled (third match).
  - 0x91 and 0x22 match.
  - err_cnt=0 and expected=nxt(0x22) at end.
- Single error while locked: after the lock-on sequence, send 0x55 in place of nxt(0x22), then the correct continuation.
  - One err_pulse; err_cnt=1; locked stays high.
- Loss of lock: after lock, send two wrong words (LOSS_CNT=2).
  - err_cnt=2; locked falls on the second miss edge.
  - Then resend 0x01,0x02,0x04,0x08: locked rises again.
- Zero handling:
  - Stream 0x00,0x00,0x01 from reset: stays in SEARCH for both zeros; expected=0x02 after 0x01.
  - A 0x00 during VERIFY returns the FSM to SEARCH.
- Gaps and clear: lock-on sequence with data_valid low for 3 cycles between words.
  - Identical result to the gap-free run.
  - Assert err_clr together with a mismatch: err_cnt=0 and err_pulse=1.
- Async reset mid-lock: drop clr_n between clock edges while locked with err_cnt=5.
  - locked, err_cnt and expected read 0 immediately, without waiting for clk.
